rule110_row_loader: RTL

- Byte-serial host port for a full 128-cell Rule 110 row.
- The host writes an arbitrary initial row one byte at a time, commands a burst of N generations, then reads the evolved row back byte by byte.
- This is the load/unload side of the automaton core: every cell is reachable, not just a reset-time seed plus a fixed low-order window.
- Sits between the tile pins (ui/uio) and the cell register.

---
 rtl/rule110_row_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/rule110_row_loader.sv
// Byte-serial load/step/unload port for a NUM_CELLS-wide Rule 110 row; ring edges when RULE110_WRAP_EN is defined.
// WRITE/READ/SEEK take one cycle in IDLE; STEP N holds busy for N cycles and drops cmd_ready meanwhile.
module rule110_row_loader #(
  parameter int NUM_CELLS = 128,
  parameter int GEN_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd,
  input  logic [7:0]                      data_in,
  output logic [7:0]                      data_out,
  output logic                            data_valid,
  output logic                            busy,
  output logic [$clog2(NUM_CELLS/8)-1:0]  ptr
);

  localparam int NUM_BYTES = NUM_CELLS / 8;
  localparam int PTR_W     = $clog2(NUM_BYTES);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [NUM_CELLS-1:0] r_row;
  logic [PTR_W-1:0]     r_ptr;
  logic [0:0]           r_state;
  logic [GEN_W-1:0]     r_gen;
  logic [7:0]           r_data_out;
  logic                 r_data_valid;

  logic                 w_accept;
  logic [PTR_W+2:0]     w_bit_base;
  logic [PTR_W-1:0]     w_ptr_inc;
  logic [PTR_W-1:0]     w_seek;
  logic [GEN_W-1:0]     w_gen_req;
  logic                 w_edge_l;
  logic                 w_edge_r;
  logic [NUM_CELLS-1:0] w_left;
  logic [NUM_CELLS-1:0] w_right;
  logic [NUM_CELLS-1:0] w_next_row;

  assign w_accept   = cmd_valid & cmd_ready;
  assign w_bit_base = {r_ptr, 3'b000};
  assign w_ptr_inc  = (r_ptr == PTR_W'(NUM_BYTES - 1)) ? '0 : r_ptr + 1'b1;
  assign w_seek     = PTR_W'(32'(data_in) % NUM_BYTES);
  assign w_gen_req  = data_in[GEN_W-1:0];

`ifdef RULE110_WRAP_EN
  assign w_edge_l = r_row[0];
  assign w_edge_r = r_row[NUM_CELLS-1];
`else
  assign w_edge_l = 1'b0;
  assign w_edge_r = 1'b0;
`endif

  // left neighbour of cell i is cell i+1; right neighbour is cell i-1
  assign w_left     = {w_edge_l, r_row[NUM_CELLS-1:1]};
  assign w_right    = {r_row[NUM_CELLS-2:0], w_edge_r};
  // Rule 110 reduces to (C ^ R) | (C & ~L)
  assign w_next_row = (r_row ^ w_right) | (r_row & ~w_left);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_ptr        <= '0;
      r_state      <= S_IDLE;
      r_gen        <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd)
              OP_WRITE: begin
                r_row[w_bit_base +: 8] <= data_in;
                r_ptr                  <= w_ptr_inc;
              end
              OP_READ: begin
                r_data_out   <= r_row[w_bit_base +: 8];
                r_data_valid <= 1'b1;
                r_ptr        <= w_ptr_inc;
              end
              OP_STEP: begin
                if (w_gen_req != '0) begin
                  r_gen   <= w_gen_req;
                  r_state <= S_RUN;
                end
              end
              default: r_ptr <= w_seek;
            endcase
          end
        end
        default: begin
          r_row <= w_next_row;
          r_gen <= r_gen - 1'b1;
          if (r_gen == GEN_W'(1)) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN);
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign ptr        = r_ptr;

endmodule
